// File: rtl/online_result_collector_if.sv
// Handshake bundle between an online multiplier, the result collector and the
// consumer of completed frames.
//   z / z_valid / z_ready                 : signed-digit stream, MSD first
//   result / result_valid / result_ready  : completed two's-complement fraction
//   digit_err                             : sticky illegal/unexpected digit flag
// master : digit producer + result consumer side
// slave  : the collector
interface online_result_collector_if #(
  parameter int NO_OF_DIGITS = 4,
  parameter int RADIX_BITS   = 2
);
  logic [RADIX_BITS-1:0]  z;
  logic                   z_valid;
  logic                   z_ready;
  logic [NO_OF_DIGITS:0]  result;
  logic                   result_valid;
  logic                   result_ready;
  logic                   digit_err;

  modport master (
    output z, z_valid, result_ready,
    input  z_ready, result, result_valid, digit_err
  );

  modport slave (
    input  z, z_valid, result_ready,
    output z_ready, result, result_valid, digit_err
  );
endinterface

// File: rtl/online_result_collector.sv
// Collects the signed-digit output of an online multiplier into a
// two's-complement fraction. The first DELTA digits of each frame are the
// online delay and are discarded; the next NO_OF_DIGITS digits are converted
// on the fly (Q / QM pair, selection and concatenation only) and the final Q
// is presented on result until the consumer takes it.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of online_result_collector_if (digit stream in,
//              result handshake out, sticky digit_err)
module online_result_collector #(
  parameter int NO_OF_DIGITS = 4,
  parameter int DELTA        = 3,
  parameter int RADIX_BITS   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  online_result_collector_if.slave bus
);

  localparam int W  = NO_OF_DIGITS + 1;
  localparam int CW = $clog2(DELTA + NO_OF_DIGITS + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SKIP    = 2'd1;
  localparam logic [1:0] COLLECT = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  // Weight of the first fraction digit (2^-1) and the -1 encoding QM must
  // hold before digit 1 so that QM = Q - 2^-j is true from j = 0.
  localparam logic [W-1:0] FIRST_MASK = W'(1) << (NO_OF_DIGITS - 1);
  localparam logic [W-1:0] MINUS_ONE  = W'(1) << NO_OF_DIGITS;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q, qm, mask;
  logic [W-1:0]  q_nxt, qm_nxt;
  logic [W-1:0]  result_r;
  logic          result_valid_r;
  logic          err_r;

  logic xfer, d_pos, d_neg, d_zero, d_bad, delay_slot;

  assign bus.z_ready      = (state != HOLD);
  assign bus.result       = result_r;
  assign bus.result_valid = result_valid_r;
  assign bus.digit_err    = err_r;

  assign xfer       = bus.z_valid && bus.z_ready;
  assign d_pos      = (bus.z == RADIX_BITS'(1));
  assign d_neg      = (bus.z == {RADIX_BITS{1'b1}});
  assign d_zero     = (bus.z == '0);
  assign d_bad      = !(d_pos || d_neg || d_zero);
  assign delay_slot = (state == IDLE) || (state == SKIP);

  // On-the-fly conversion: mask is one-hot at weight 2^-j, and that bit is
  // zero in both Q and QM, so "+ 2^-j" is an OR. Illegal digits act as 0.
  always_comb begin
    q_nxt  = q;
    qm_nxt = qm | mask;
    if (d_pos) begin
      q_nxt  = q | mask;
      qm_nxt = q;
    end else if (d_neg) begin
      q_nxt  = qm | mask;
      qm_nxt = qm;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      q              <= '0;
      qm             <= '0;
      mask           <= '0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      // Sticky; never gates FSM progress.
      if (xfer && (d_bad || (delay_slot && !d_zero)))
        err_r <= 1'b1;

      case (state)
        IDLE: begin
          if (xfer) begin
            cnt   <= CW'(1);
            q     <= '0;
            qm    <= MINUS_ONE;
            mask  <= FIRST_MASK;
            state <= (DELTA > 1) ? SKIP : COLLECT;
          end
        end
        SKIP: begin
          if (xfer) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(DELTA - 1))
              state <= COLLECT;
          end
        end
        COLLECT: begin
          if (xfer) begin
            cnt  <= cnt + 1'b1;
            q    <= q_nxt;
            qm   <= qm_nxt;
            mask <= mask >> 1;
            // mask[0] marks the 2^-NO_OF_DIGITS digit, the last of the frame.
            if (mask[0]) begin
              result_r       <= q_nxt;
              result_valid_r <= 1'b1;
              state          <= HOLD;
            end
          end
        end
        HOLD: begin
          if (result_valid_r && bus.result_ready) begin
            result_valid_r <= 1'b0;
            cnt            <= '0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_online_result_collector.sv
module tb_online_result_collector;

  localparam int ND = 4;
  localparam int DL = 3;
  localparam int RB = 2;
  localparam int FL = ND + DL;

  typedef struct packed {
    logic [ND:0] res;
    logic        err;
  } sb_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic err_model = 1'b0;
  sb_t  sb[$];

  always #5 clk = ~clk;

  online_result_collector_if #(.NO_OF_DIGITS(ND), .RADIX_BITS(RB)) bus ();

  online_result_collector #(.NO_OF_DIGITS(ND), .DELTA(DL), .RADIX_BITS(RB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame of FL digits; gap inserts a z_valid=0 cycle (with a
  // nonzero z) after every digit but the last. hold = cycles result_ready
  // stays low once the result is up.
  task automatic run_frame(input string tag, input logic [RB-1:0] d[FL], input bit gap,
                           input int hold, input logic [ND:0] exp_res, input logic sets_err);
    sb_t e;
    err_model = err_model | sets_err;
    sb.push_back('{res: exp_res, err: err_model});
    bus.result_ready = (hold == 0);
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      if (i == FL - 1) chk({tag, "_valid_early"}, 32'(bus.result_valid), 32'd0);
      chk({tag, "_zready"}, 32'(bus.z_ready), 32'd1);
      bus.z       = d[i];
      bus.z_valid = 1'b1;
      @(posedge clk);
      if (gap && i < FL - 1) begin
        @(negedge clk);
        bus.z_valid = 1'b0;
        bus.z       = 2'b01;
        @(posedge clk);
      end
    end
    @(negedge clk);
    bus.z_valid = 1'b0;
    bus.z       = '0;
    chk({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
    chk({tag, "_zready_hold"}, 32'(bus.z_ready), 32'd0);
    e = sb.pop_front();
    chk({tag, "_result"}, 32'(bus.result), 32'(e.res));
    chk({tag, "_err"}, 32'(bus.digit_err), 32'(e.err));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(bus.result_valid), 32'd1);
      chk({tag, "_hold_result"}, 32'(bus.result), 32'(e.res));
      chk({tag, "_hold_zready"}, 32'(bus.z_ready), 32'd0);
    end
    bus.result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_accepted_valid"}, 32'(bus.result_valid), 32'd0);
    chk({tag, "_idle_zready"}, 32'(bus.z_ready), 32'd1);
  endtask

  initial begin
    logic [RB-1:0] f[FL];

    reset_n          = 1'b0;
    bus.z            = '0;
    bus.z_valid      = 1'b0;
    bus.result_ready = 1'b0;

    @(negedge clk);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_err", 32'(bus.digit_err), 32'd0);
    chk("rst_zready", 32'(bus.z_ready), 32'd1);
    reset_n = 1'b1;

    // 7/16 gap-free, result_ready high during digits (no effect outside HOLD)
    f = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01};
    run_frame("f7_16", f, 1'b0, 0, 5'b00111, 1'b0);

    // -15/16
    f = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
    run_frame("fm15_16", f, 1'b0, 0, 5'b10001, 1'b0);

    // Same as 7/16 with z_valid toggling every cycle
    f = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01};
    run_frame("f7_16_gap", f, 1'b1, 0, 5'b00111, 1'b0);

    // 1/16 with consumer backpressure for 5 cycles
    f = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    run_frame("f1_16_hold", f, 1'b0, 5, 5'b00001, 1'b0);

    // Nonzero delay digit and illegal digit: error flagged, frame completes
    f = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    run_frame("f_err", f, 1'b0, 0, 5'b00000, 1'b1);

    // Abort a frame after its 5th digit with a reset pulse
    f = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.z       = f[i];
      bus.z_valid = 1'b1;
    end
    @(negedge clk);
    bus.z_valid = 1'b0;
    reset_n     = 1'b0;
    #1;
    chk("mid_rst_err", 32'(bus.digit_err), 32'd0);
    chk("mid_rst_valid", 32'(bus.result_valid), 32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    chk("mid_rst_zready", 32'(bus.z_ready), 32'd1);
    @(negedge clk);
    reset_n   = 1'b1;
    err_model = 1'b0;

    f = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    run_frame("f15_16_after_rst", f, 1'b0, 0, 5'b01111, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
